// File: rtl/reservation_station_pkg.sv
// Shared defines for the reservation station and ALU:
// opcode encodings, tag width, depth and entry layout.
package reservation_station_pkg;

    localparam int XLEN     = 32;
    localparam int OP_W     = 6;
    localparam int ROB_W    = 4;
    localparam int RS_DEPTH = 8;
    localparam int RS_IDX_W = 3;

    localparam logic [OP_W-1:0] OP_NOP  = 6'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 6'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 6'd2;
    localparam logic [OP_W-1:0] OP_AND  = 6'd3;
    localparam logic [OP_W-1:0] OP_OR   = 6'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 6'd5;
    localparam logic [OP_W-1:0] OP_ADDI = 6'd10;
    localparam logic [OP_W-1:0] OP_ANDI = 6'd11;

    typedef struct packed {
        logic             busy;
        logic [OP_W-1:0]  opcode;
        logic [XLEN-1:0]  vj;
        logic [XLEN-1:0]  vk;
        logic [ROB_W-1:0] qj;
        logic [ROB_W-1:0] qk;
        logic             qj_busy;
        logic             qk_busy;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic [ROB_W-1:0] rob;
    } rs_entry_t;

endpackage

// File: rtl/reservation_station_prio_enc8.sv
// Lowest-index set-bit finder over an 8-bit request vector.
module rs_prio_enc8 (
    input  logic [7:0] req,
    output logic       found,
    output logic [2:0] idx
);

    always_comb begin
        found = |req;
        idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/reservation_station.sv
// 8-entry reservation station: dispatch with forwarding,
// dual-CDB snoop, in-order-by-index single issue.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback,
    input  logic             dsp_valid,
    input  logic [OP_W-1:0]  dsp_opcode,
    input  logic [XLEN-1:0]  dsp_vj,
    input  logic [XLEN-1:0]  dsp_vk,
    input  logic             dsp_qj_busy,
    input  logic             dsp_qk_busy,
    input  logic [ROB_W-1:0] dsp_qj,
    input  logic [ROB_W-1:0] dsp_qk,
    input  logic [XLEN-1:0]  dsp_imm,
    input  logic [XLEN-1:0]  dsp_pc,
    input  logic [ROB_W-1:0] dsp_rob,
    output logic             rs_full,
    input  logic             cdb_alu_valid,
    input  logic [ROB_W-1:0] cdb_alu_tag,
    input  logic [XLEN-1:0]  cdb_alu_val,
    input  logic             cdb_lsb_valid,
    input  logic [ROB_W-1:0] cdb_lsb_tag,
    input  logic [XLEN-1:0]  cdb_lsb_val,
    output logic             RS_sgn,
    output logic [OP_W-1:0]  RS_opcode,
    output logic [XLEN-1:0]  lhs,
    output logic [XLEN-1:0]  rhs,
    output logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  pc,
    output logic [ROB_W-1:0] ROB_entry
);

    rs_entry_t ent [RS_DEPTH];

    logic [RS_DEPTH-1:0] free_vec;
    logic [RS_DEPTH-1:0] ready_vec;
    logic                free_found;
    logic                ready_found;
    logic [RS_IDX_W-1:0] free_idx;
    logic [RS_IDX_W-1:0] ready_idx;

    logic [XLEN:0] snp_j [RS_DEPTH];
    logic [XLEN:0] snp_k [RS_DEPTH];
    logic [XLEN:0] new_j;
    logic [XLEN:0] new_k;
    rs_entry_t     new_ent;

    // Returns {still_pending, value}; the ALU bus wins a tag tie.
    function automatic logic [XLEN:0] fwd(
        input logic             pend,
        input logic [ROB_W-1:0] tag,
        input logic [XLEN-1:0]  val
    );
        if (pend && cdb_alu_valid && cdb_alu_tag == tag)
            return {1'b0, cdb_alu_val};
        else if (pend && cdb_lsb_valid && cdb_lsb_tag == tag)
            return {1'b0, cdb_lsb_val};
        else
            return {pend, val};
    endfunction

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            free_vec[i]  = !ent[i].busy;
            ready_vec[i] = ent[i].busy && !ent[i].qj_busy
                           && !ent[i].qk_busy;
            snp_j[i] = fwd(ent[i].qj_busy, ent[i].qj, ent[i].vj);
            snp_k[i] = fwd(ent[i].qk_busy, ent[i].qk, ent[i].vk);
        end
    end

    always_comb begin
        new_j           = fwd(dsp_qj_busy, dsp_qj, dsp_vj);
        new_k           = fwd(dsp_qk_busy, dsp_qk, dsp_vk);
        new_ent         = '0;
        new_ent.busy    = 1'b1;
        new_ent.opcode  = dsp_opcode;
        new_ent.qj_busy = new_j[XLEN];
        new_ent.vj      = new_j[XLEN-1:0];
        new_ent.qk_busy = new_k[XLEN];
        new_ent.vk      = new_k[XLEN-1:0];
        new_ent.qj      = dsp_qj;
        new_ent.qk      = dsp_qk;
        new_ent.imm     = dsp_imm;
        new_ent.pc      = dsp_pc;
        new_ent.rob     = dsp_rob;
    end

    rs_prio_enc8 u_free_enc (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_prio_enc8 u_ready_enc (
        .req   (ready_vec),
        .found (ready_found),
        .idx   (ready_idx)
    );

    assign rs_full = !free_found;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RS_DEPTH; i++) ent[i] <= '0;
            RS_sgn    <= 1'b0;
            RS_opcode <= '0;
            lhs       <= '0;
            rhs       <= '0;
            imm       <= '0;
            pc        <= '0;
            ROB_entry <= '0;
        end else if (!rdy) begin
            RS_sgn <= 1'b0;
        end else if (rollback) begin
            for (int i = 0; i < RS_DEPTH; i++) ent[i].busy <= 1'b0;
            RS_sgn <= 1'b0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (ent[i].busy) begin
                    {ent[i].qj_busy, ent[i].vj} <= snp_j[i];
                    {ent[i].qk_busy, ent[i].vk} <= snp_k[i];
                end
            end
            RS_sgn <= ready_found;
            if (ready_found) begin
                RS_opcode <= ent[ready_idx].opcode;
                lhs       <= ent[ready_idx].vj;
                rhs       <= ent[ready_idx].vk;
                imm       <= ent[ready_idx].imm;
                pc        <= ent[ready_idx].pc;
                ROB_entry <= ent[ready_idx].rob;
                ent[ready_idx].busy <= 1'b0;
            end
            // Free slot comes from start-of-cycle state, so it never
            // aliases the entry being issued at this edge.
            if (dsp_valid && free_found)
                ent[free_idx] <= new_ent;
        end
    end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 clk  input  1  system clock; all state updates on its rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
REQ-003 rdy  input  1  global ready; rdy=0 freezes all state.
REQ-004 rollback  input  1  misprediction flush.
REQ-005 dsp_valid  input  1  dispatch request from decoder.
REQ-006 dsp_opcode  input  6  internal opcode (shared defines).
REQ-007 dsp_vj / dsp_vk  input  32 each  operand values, valid when matching busy flag=0.
REQ-008 dsp_qj_busy / dsp_qk_busy  input  1 each  operand still pending.
REQ-009 dsp_qj / dsp_qk  input  4 each  producing ROB tag.
REQ-010 dsp_imm, dsp_pc  input  32 each  immediate, instruction PC.
REQ-011 dsp_rob  input  4  destination ROB tag.
REQ-012 rs_full  output  1  no free entry.
REQ-013 cdb_alu_valid, cdb_alu_tag[4], cdb_alu_val[32]  input  ALU broadcast.
REQ-014 cdb_lsb_valid, cdb_lsb_tag[4], cdb_lsb_val[32]  input  load/store broadcast.
REQ-015 RS_sgn  output  1  issue strobe to ALU, registered.
REQ-016 RS_opcode[6], lhs[32], rhs[32], imm[32], pc[32], ROB_entry[4]  output  registered issue payload.

Function
REQ-017 Storage: 8 entries; each holds busy, opcode, Vj, Vk, Qj, Qk, qj_busy, qk_busy, imm, pc, rob.
REQ-018 rs_full = 1 when all 8 entries are busy, evaluated combinationally from current state only.
REQ-019 Dispatch: dsp_valid=1, rs_full=0 -> write the lowest-index free entry; dsp_valid while rs_full=1 is ignored with no state change.
REQ-020 Dispatch-time forwarding: if dsp_qj_busy=1 and a same-cycle valid CDB tag equals dsp_qj, store that value with qj_busy=0; same for k.
REQ-021 Snoop: every busy entry with qj_busy=1 and a matching valid CDB tag captures the value and clears qj_busy; same for k; both CDBs are serviced in the same cycle.
REQ-022 Ready = busy & !qj_busy & !qk_busy, evaluated on start-of-cycle state; same-cycle CDB capture takes effect the next cycle.
REQ-023 Issue: when one or more entries are ready, select the lowest-index ready entry and load the payload registers.
REQ-024 Issue also sets RS_sgn=1 and frees the selected entry at the same edge; with no ready entry, RS_sgn=0 and the payload registers hold.
REQ-025 Latency: dispatch of a fully-ready op -> RS_sgn=1 on the second rising edge after dispatch (edge 1 write, edge 2 issue).
REQ-026 At most 1 issue per cycle; RS_sgn is a 1-cycle pulse per issued op.
REQ-027 An entry freed by issue is not reusable by a dispatch in the same cycle; free-slot selection uses start-of-cycle state.
REQ-028 rollback=1 (with rdy=1): clear all busy bits and RS_sgn at the next edge; simultaneous dispatch and issue are discarded.
REQ-029 rdy=0: no dispatch, capture, issue or rollback; RS_sgn is driven 0 while the payload holds; rollback has priority once rdy returns.
REQ-030 A CDB tag with no matching waiter is ignored; if both CDBs carry the same tag, the ALU value wins.

Reset
REQ-031 rst=0 asynchronously clears all busy, qj_busy and qk_busy bits, and RS_sgn.
REQ-032 rst=0 also clears RS_opcode, lhs, rhs, imm, pc and ROB_entry to 0; rs_full then reads 0.
REQ-033 Reset mid-operation discards every stored entry; no issue occurs on the first edge after release.

Structure
REQ-034 The opcode encodings, ROB tag width (4) and RS depth (8) constants live in the shared defines file used by the ALU.
REQ-035 One sub-module, rs_prio_enc8, provides the lowest-index find for both the free slot and the ready entry (two instances).

Verification
REQ-036 ADDI x, vj=5, imm=3, no pending operands -> RS_sgn=1 two edges later with lhs=5, imm=3, RS_opcode=ADDI.
REQ-037 ADD with qj_busy=1, qj=2 -> no issue; cdb_alu_tag=2, val=0x10 -> issue the next cycle with lhs=0x10.
REQ-038 Dispatch 8 ops all waiting on tag 7 -> rs_full=1; a 9th dispatch is dropped; cdb_lsb_tag=7 -> 8 consecutive RS_sgn pulses, entries 0..7 in order.
REQ-039 Dispatch with qk=3 while cdb_alu_tag=3, val=9 in the same cycle -> entry stored ready; issue with rhs=9.
REQ-040 4 entries pending plus rollback=1 -> rs_full=0, no RS_sgn in any later cycle, and a new dispatch goes to entry 0.
REQ-041 Ready entry, rdy=0 for 3 cycles -> RS_sgn stays 0; after rdy=1 the op issues exactly once.
